// File: rtl/sprite_fetch_scheduler_pkg.sv
// Shared types and constants for the sprite fetch scheduler.
package sprite_sched_pkg;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       vis;
    } slot_t;
endpackage

// File: rtl/sprite_fetch_scheduler_if.sv
// Config port of the sprite fetch scheduler: slot position writes and pending flag.
interface sprite_fetch_scheduler_if #(
    parameter int N_SLOTS = 4
);
    localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

    logic              cfg_we;
    logic [SLOT_W-1:0] cfg_slot;
    logic [9:0]        cfg_x;
    logic [9:0]        cfg_y;
    logic              cfg_vis;
    logic              cfg_pending;

    modport master (output cfg_we, cfg_slot, cfg_x, cfg_y, cfg_vis, input cfg_pending);
    modport slave  (input cfg_we, cfg_slot, cfg_x, cfg_y, cfg_vis, output cfg_pending);
endinterface

// File: rtl/sprite_fetch_scheduler_slot_hit.sv
// One sprite slot: coverage test of (DrawX, DrawY) and the sprite-local ROM address.
module sprite_slot_hit
    import sprite_sched_pkg::*;
#(
    parameter int SPRITE_W = 35,
    parameter int SPRITE_H = 35,
    parameter int ADDR_W   = 11
) (
    input  slot_t             i_slot,
    input  logic [9:0]        i_x,
    input  logic [9:0]        i_y,
    output logic              o_hit,
    output logic [ADDR_W-1:0] o_addr
);
    // 11-bit compares so sx+SPRITE_W-1 never wraps near the right/bottom edge.
    logic [10:0] w_x, w_y, w_sx, w_sy, w_dx, w_dy;

    assign w_x  = {1'b0, i_x};
    assign w_y  = {1'b0, i_y};
    assign w_sx = {1'b0, i_slot.x};
    assign w_sy = {1'b0, i_slot.y};
    assign w_dx = w_x - w_sx;
    assign w_dy = w_y - w_sy;

    assign o_hit = i_slot.vis
                && (w_x >= w_sx) && (w_x <= w_sx + 11'(SPRITE_W - 1))
                && (w_y >= w_sy) && (w_y <= w_sy + 11'(SPRITE_H - 1));

    assign o_addr = ADDR_W'(32'(w_dy) * 32'(SPRITE_W) + 32'(w_dx));
endmodule

// File: rtl/sprite_fetch_scheduler.sv
// Shares one sprite ROM between N_SLOTS positioned sprites: hit/grant, ROM address, aligned palette index.
module sprite_fetch_scheduler
    import sprite_sched_pkg::*;
#(
    parameter int N_SLOTS         = 4,
    parameter int SPRITE_W        = 35,
    parameter int SPRITE_H        = 35,
    parameter int ADDR_W          = 11,
    parameter int IDX_W           = 1,
    parameter int TRANSPARENT_IDX = 0
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    sprite_fetch_scheduler_if.slave cfg,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pix_index,
    output logic              pix_hit,
    output logic              pix_blank
);
    localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

    slot_t r_stage  [N_SLOTS];
    slot_t r_active [N_SLOTS];
    logic  r_pending;
    logic [ADDR_W-1:0] r_addr;
    logic  r_hit0;
    logic [1:0] r_blank_pipe;
    logic [IDX_W-1:0] r_idx;
    logic  r_hit;

    logic [N_SLOTS-1:0]             w_hit;
    logic [N_SLOTS-1:0][ADDR_W-1:0] w_addr_s;
    logic              w_any;
    logic [ADDR_W-1:0] w_addr;
    logic              w_fs;
    logic              w_slot_ok;
    logic              w_wr;

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
        sprite_slot_hit #(
            .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H), .ADDR_W(ADDR_W)
        ) u_hit (
            .i_slot(r_active[g]), .i_x(DrawX), .i_y(DrawY),
            .o_hit(w_hit[g]), .o_addr(w_addr_s[g])
        );
    end

    // Slot indices past N_SLOTS only exist when N_SLOTS is not a power of two.
    if ((1 << SLOT_W) > N_SLOTS) begin : g_slot_chk
        assign w_slot_ok = (int'(cfg.cfg_slot) < N_SLOTS);
    end else begin : g_slot_all
        assign w_slot_ok = 1'b1;
    end

    assign w_fs = (DrawX == 10'd0) && (DrawY == 10'd0);
    assign w_wr = cfg.cfg_we && w_slot_ok;

    // Scan high to low so the lowest-index hit is the final assignment and wins.
    always_comb begin
        w_any  = 1'b0;
        w_addr = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (blank && w_hit[i]) begin
                w_any  = 1'b1;
                w_addr = w_addr_s[i];
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                r_stage[i]  <= '0;
                r_active[i] <= '0;
            end
            r_pending    <= 1'b0;
            r_addr       <= '0;
            r_hit0       <= 1'b0;
            r_blank_pipe <= '0;
            r_idx        <= '0;
            r_hit        <= 1'b0;
        end else begin
            // Active takes the pre-write staging value when a write coincides with frame start.
            if (w_fs) begin
                for (int i = 0; i < N_SLOTS; i++) r_active[i] <= r_stage[i];
            end
            if (w_wr) begin
                r_stage[cfg.cfg_slot] <= {cfg.cfg_x, cfg.cfg_y, cfg.cfg_vis};
                r_pending             <= 1'b1;
            end else if (w_fs) begin
                r_pending <= 1'b0;
            end
            r_addr       <= w_addr;
            r_hit0       <= w_any;
            r_blank_pipe <= {r_blank_pipe[0], blank};
            r_idx        <= rom_q;
            r_hit        <= r_hit0 && (rom_q != IDX_W'(TRANSPARENT_IDX));
        end
    end

    assign cfg.cfg_pending = r_pending;
    assign rom_address     = r_addr;
    assign pix_index       = r_idx;
    assign pix_hit         = r_hit;
    assign pix_blank       = r_blank_pipe[1];
endmodule
